// File: rtl/nes_dma_pkg.sv
// Shared definitions for the NES DMA engines: FSM state encoding and register map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nes_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_t;

    localparam logic [15:0] OAM_DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_DATA_REG = 16'h2004;
    localparam int          OAM_SIZE     = 256;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: on a $4014 write, halts the CPU and copies XFER_LEN bytes from page P to OAM ($2004).
// Latency: halt rises 1 CPU cycle after trigger; first OAM write 2-3 CPU cycles after; then 1 byte per 2 cycles.
// Backpressure: none; the engine only advances on cpu_ce and stalls (outputs held) while cpu_ce=0.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cpu_ce                CPU-cycle enable (one CPU cycle per clk edge with cpu_ce=1)
//   reg_we, reg_wdata     decoded $4014 write and source page number
//   cpu_halt              CPU RDY hold, high for the whole transfer
//   mem_addr, mem_rd      CPU-bus read address / read strobe, mem_rdata is the returned byte
//   oam_we, oam_wdata     write strobe and data towards the PPU $2004 port
//   done                  single-clk pulse at transfer completion
//
// Build option: define OAM_DMA_ALIGN_EN to add the parity bit and the ALIGN state, which
// keeps every READ on an even CPU cycle (513/514-cycle halts as on real hardware).
// Without it ALIGN is never entered and every transfer takes 1 + 2*XFER_LEN cycles.
module oam_dma
    import nes_dma_pkg::*;
#(
    parameter int XFER_LEN = 256,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_ce,
    input  logic              reg_we,
    input  logic [7:0]        reg_wdata,
    output logic              cpu_halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              oam_we,
    output logic [7:0]        oam_wdata,
    output logic              done
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state;
    dma_state_t state_nxt;
    logic [7:0] page;
    logic [7:0] page_nxt;
    logic [7:0] idx;
    logic [7:0] idx_nxt;
    logic       fin;
    logic       go_align;

`ifdef OAM_DMA_ALIGN_EN
    // Parity of the current CPU cycle; 0 = even. Free-running from reset.
    logic odd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            odd <= 1'b0;
        end else if (cpu_ce) begin
            odd <= ~odd;
        end
    end

    // The cycle after HALT has parity ~odd; if that is odd, burn one cycle so READ lands on even.
    assign go_align = ~odd;
`else
    assign go_align = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        page_nxt  = page;
        idx_nxt   = idx;
        fin       = 1'b0;
        if (cpu_ce) begin
            case (state)
                ST_IDLE: begin
                    if (reg_we) begin
                        state_nxt = ST_HALT;
                        page_nxt  = reg_wdata;
                        idx_nxt   = 8'd0;
                    end
                end
                ST_HALT:  state_nxt = go_align ? ST_ALIGN : ST_READ;
                ST_ALIGN: state_nxt = ST_READ;
                ST_READ:  state_nxt = ST_WRITE;
                ST_WRITE: begin
                    idx_nxt = idx + 8'd1;
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_IDLE;
                        fin       = 1'b1;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they are valid for the whole CPU cycle
    // of that state. With cpu_ce=0 the next state equals the current one, so everything holds.
    // oam_wdata doubles as the read buffer: it captures the byte at the edge that ends READ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            page      <= 8'd0;
            idx       <= 8'd0;
            cpu_halt  <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            oam_we    <= 1'b0;
            oam_wdata <= 8'd0;
            done      <= 1'b0;
        end else begin
            page     <= page_nxt;
            idx      <= idx_nxt;
            cpu_halt <= (state_nxt != ST_IDLE);
            mem_rd   <= (state_nxt == ST_READ);
            oam_we   <= (state_nxt == ST_WRITE);
            done     <= fin;
            if (cpu_ce && state_nxt == ST_READ) begin
                mem_addr <= ADDR_W'({page_nxt, idx_nxt});
            end
            if (cpu_ce && state == ST_READ) begin
                oam_wdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: randomized keys/parities, monitor-collected transcripts
// compared against the transfer rules (halt length, address sequence, OAM contents, done).
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_ce = 1'b0;
    logic        reg_we = 1'b0;
    logic        reg_we4 = 1'b0;
    logic [7:0]  reg_wdata = 8'd0;
    logic [7:0]  key = 8'hA5;

    logic        cpu_halt, mem_rd, oam_we, done;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata, oam_wdata;
    logic        cpu_halt4, mem_rd4, oam_we4, done4;
    logic [15:0] mem_addr4;
    logic [7:0]  mem_rdata4, oam_wdata4;

    // Memory model: byte at address A is A[7:0] ^ key.
    assign mem_rdata  = mem_addr[7:0] ^ key;
    assign mem_rdata4 = mem_addr4[7:0] ^ key;

    oam_dma #(.XFER_LEN(256), .ADDR_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .cpu_ce(cpu_ce), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .cpu_halt(cpu_halt), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .oam_we(oam_we), .oam_wdata(oam_wdata), .done(done)
    );

    oam_dma #(.XFER_LEN(4), .ADDR_W(16)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .cpu_ce(cpu_ce), .reg_we(reg_we4), .reg_wdata(reg_wdata),
        .cpu_halt(cpu_halt4), .mem_addr(mem_addr4), .mem_rd(mem_rd4), .mem_rdata(mem_rdata4),
        .oam_we(oam_we4), .oam_wdata(oam_wdata4), .done(done4)
    );

    always #5 clk = ~clk;

    // cpu_ce generator: one enable every ce_div clocks.
    int ce_div = 1;
    int ce_cnt = 0;
    always @(posedge clk) begin
        #1;
        ce_cnt = (ce_cnt + 1) % ce_div;
        cpu_ce = (ce_cnt == 0);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: CPU cycle index since reset and per-transfer transcripts.
    int cyc = 0;
    int trig_cyc, first_halt, last_halt, halt_cnt, first_rd, done_cnt, done_cyc;
    int trig4, halt4_cnt, done4_cnt;
    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    logic [7:0]  wr4_q[$];

    task automatic clear_stats();
        trig_cyc = -1; first_halt = -1; last_halt = -1; halt_cnt = 0;
        first_rd = -1; done_cnt = 0; done_cyc = -1;
        trig4 = -1; halt4_cnt = 0; done4_cnt = 0;
        rd_q.delete(); wr_q.delete(); wr4_q.delete();
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            cyc = 0;
        end else begin
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (done4) done4_cnt++;
            if (cpu_ce) begin
                if (reg_we && trig_cyc < 0) trig_cyc = cyc;
                if (reg_we4 && trig4 < 0) trig4 = cyc;
                if (cpu_halt) begin
                    if (first_halt < 0) first_halt = cyc;
                    halt_cnt++;
                    last_halt = cyc;
                end
                if (mem_rd) begin
                    if (first_rd < 0) first_rd = cyc;
                    rd_q.push_back(mem_addr);
                end
                if (oam_we) wr_q.push_back(oam_wdata);
                if (cpu_halt4) halt4_cnt++;
                if (oam_we4) wr4_q.push_back(oam_wdata4);
                cyc++;
            end
        end
    end

    // Issue a $4014 write during a CPU cycle of the requested parity (-1 = any).
    task automatic trigger(input logic [7:0] p, input int par, input bit sel4);
        int n;
        n = 0;
        @(posedge clk); #2;
        while (!(cpu_ce && (par < 0 || (cyc % 2) == par)) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        reg_wdata = p;
        if (sel4) reg_we4 = 1'b1;
        else      reg_we  = 1'b1;
        @(posedge clk); #2;
        reg_we  = 1'b0;
        reg_we4 = 1'b0;
    endtask

    task automatic wait_idle(input bit sel4);
        int n;
        n = 0;
        while (!(sel4 ? (halt4_cnt > 0 && !cpu_halt4) : (halt_cnt > 0 && !cpu_halt)) && n < 20000) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 20000) check_eq("timeout", 1, 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_writes(input int cnt);
        int n;
        n = 0;
        while (wr_q.size() < cnt && n < 20000) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 20000) check_eq("wait_writes_timeout", 1, 0);
    endtask

    // Compare one 256-byte transfer's transcript with what the transfer rules require.
    task automatic check_xfer(input string name, input logic [7:0] p);
        int align;
        logic [15:0] ea;
        logic [7:0]  ed;
        align = 0;
`ifdef OAM_DMA_ALIGN_EN
        align = trig_cyc % 2;
`endif
        check_eq({name, "_trig_seen"}, (trig_cyc >= 0), 1);
        check_eq({name, "_halt_start"}, first_halt, trig_cyc + 1);
        check_eq({name, "_halt_len"}, halt_cnt, 1 + align + 2 * 256);
        check_eq({name, "_first_rd"}, first_rd, trig_cyc + 2 + align);
`ifdef OAM_DMA_ALIGN_EN
        check_eq({name, "_rd_even"}, first_rd % 2, 0);
`endif
        check_eq({name, "_n_rd"}, rd_q.size(), 256);
        check_eq({name, "_n_wr"}, wr_q.size(), 256);
        for (int j = 0; j < 256; j++) begin
            ea = {p, 8'(j)};
            ed = 8'(j) ^ key;
            if (j < rd_q.size()) check_eq({name, "_addr"}, rd_q[j], ea);
            if (j < wr_q.size()) check_eq({name, "_oam"}, wr_q[j], ed);
        end
        check_eq({name, "_done_cnt"}, done_cnt, 1);
        check_eq({name, "_done_at_drop"}, done_cyc, last_halt + 1);
    endtask

    initial begin
        int align4;
        clear_stats();
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_halt", cpu_halt, 0);
        check_eq("rst_rd", mem_rd, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_we", oam_we, 0);
        check_eq("rst_wdata", oam_wdata, 0);
        check_eq("rst_done", done, 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // 1: even-cycle trigger, page $02, data i^A5.
        key = 8'hA5;
        clear_stats();
        trigger(8'h02, 0, 1'b0);
        wait_idle(1'b0);
        check_xfer("even", 8'h02);

        // 2: odd-cycle trigger, random page and data.
        key = 8'($urandom);
        clear_stats();
        trigger(8'($urandom), 1, 1'b0);
        wait_idle(1'b0);
        check_xfer("odd", reg_wdata);

        // 3: second $4014 write in the middle of a transfer is ignored.
        key = 8'($urandom);
        clear_stats();
        trigger(8'h02, int'($urandom_range(0, 1)), 1'b0);
        wait_writes(100);
        trigger(8'h03, -1, 1'b0);
        wait_idle(1'b0);
        check_xfer("retrig", 8'h02);

        // 4: reset mid-transfer, then a fresh transfer from page $07.
        key = 8'($urandom);
        clear_stats();
        trigger(8'h02, -1, 1'b0);
        wait_writes(50);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_halt", cpu_halt, 0);
        check_eq("midrst_rd", mem_rd, 0);
        check_eq("midrst_addr", mem_addr, 0);
        check_eq("midrst_we", oam_we, 0);
        check_eq("midrst_wdata", oam_wdata, 0);
        check_eq("midrst_done", done, 0);
        repeat (3) @(posedge clk);
        #2;
        clear_stats();
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        trigger(8'h07, -1, 1'b0);
        wait_idle(1'b0);
        check_xfer("post_rst", 8'h07);

        // 5: cpu_ce duty 1/3, top page $FF.
        ce_div = 3;
        key = 8'($urandom);
        clear_stats();
        trigger(8'hFF, int'($urandom_range(0, 1)), 1'b0);
        wait_idle(1'b0);
        check_xfer("slow_ff", 8'hFF);
        check_eq("slow_last_addr", (rd_q.size() == 256) ? rd_q[255] : 16'h0, 16'hFFFF);
        ce_div = 1;

        // 6: short 4-byte transfer instance.
        key = 8'($urandom);
        clear_stats();
        trigger(8'($urandom), int'($urandom_range(0, 1)), 1'b1);
        wait_idle(1'b1);
        align4 = 0;
`ifdef OAM_DMA_ALIGN_EN
        align4 = trig4 % 2;
`endif
        check_eq("len4_halt", halt4_cnt, 1 + align4 + 8);
        check_eq("len4_n_wr", wr4_q.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < wr4_q.size()) check_eq("len4_oam", wr4_q[j], 8'(j) ^ key);
        end
        check_eq("len4_done", done4_cnt, 1);
        check_eq("len4_main_idle", halt_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
